// File: rtl/wb_addr_queue.sv
// wb_addr_queue: circular store queue feeding the data cache, with a lookup that matches pending stores by 16-byte line
module wb_addr_queue #(
  parameter int DEPTH = 8,
  parameter int PTRW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enq_valid,
  input  logic [31:0]     enq_addr,
  input  logic [63:0]     enq_data,
  input  logic [1:0]      enq_size,
  output logic            full,
  output logic            empty,
  output logic [PTRW:0]   count,
  output logic            mem_req_valid,
  output logic [31:0]     mem_req_addr,
  output logic [63:0]     mem_req_data,
  output logic [1:0]      mem_req_size,
  input  logic            mem_req_ready,
  input  logic [31:0]     lookup_addr,
  output logic            lookup_hit,
  output logic            ovf
);
  logic [31:0]     addr_q [DEPTH];
  logic [63:0]     data_q [DEPTH];
  logic [1:0]      size_q [DEPTH];
  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTRW:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            enq, deq;
  logic [DEPTH-1:0] occ, match;

  assign full          = count_q == (PTRW+1)'(DEPTH);
  assign empty         = count_q == '0;
  assign count         = count_q;
  assign ovf           = ovf_q;
  assign enq           = enq_valid && !full;
  assign deq           = !empty && mem_req_ready;
  assign mem_req_valid = !empty;
  assign mem_req_addr  = addr_q[head_q];
  assign mem_req_data  = data_q[head_q];
  assign mem_req_size  = size_q[head_q];

  // Pointer/count/overflow next state; an enqueue attempted while full is dropped and flagged
  always_comb begin
    head_d  = deq ? head_q + PTRW'(1) : head_q;
    tail_d  = enq ? tail_q + PTRW'(1) : tail_q;
    count_d = count_q + (PTRW+1)'(enq) - (PTRW+1)'(deq);
    ovf_d   = ovf_q | (enq_valid & full);
  end

  // Control state, cleared asynchronously so pending stores vanish immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage is never reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= enq_addr;
      data_q[tail_q] <= enq_data;
      size_q[tail_q] <= enq_size;
    end
  end

  // An entry is occupied when its distance from head is below count
  for (genvar g = 0; g < DEPTH; g++) begin : g_lookup
    assign occ[g]   = {1'b0, PTRW'(g) - head_q} < count_q;
    assign match[g] = addr_q[g][31:4] == lookup_addr[31:4];
  end

  assign lookup_hit = |(occ & match);
endmodule

// File: tb/tb_wb_addr_queue.sv
// tb_wb_addr_queue: scoreboard bench for wb_addr_queue
module tb_wb_addr_queue;
  localparam int DEPTH = 8;
  localparam int PTRW  = 3;

  typedef struct packed {
    logic [31:0] a;
    logic [63:0] d;
    logic [1:0]  s;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enq_valid = 1'b0;
  logic [31:0]     enq_addr = '0;
  logic [63:0]     enq_data = '0;
  logic [1:0]      enq_size = '0;
  logic            full, empty, mem_req_valid, lookup_hit, ovf;
  logic [PTRW:0]   count;
  logic [31:0]     mem_req_addr;
  logic [63:0]     mem_req_data;
  logic [1:0]      mem_req_size;
  logic            mem_req_ready = 1'b0;
  logic [31:0]     lookup_addr = '0;

  ent_t sb[$];
  logic movf = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  wb_addr_queue #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data), .enq_size(enq_size),
    .full(full), .empty(empty), .count(count),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_size(mem_req_size),
    .mem_req_ready(mem_req_ready),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, check combinational outputs, cross the posedge, check state
  task automatic step(input logic ev, input logic [31:0] a, input logic [63:0] d, input logic [1:0] s,
                      input logic rdy, input logic [31:0] la);
    logic hit;
    int   n;
    enq_valid = ev; enq_addr = a; enq_data = d; enq_size = s;
    mem_req_ready = rdy; lookup_addr = la;
    #1;
    hit = 1'b0;
    foreach (sb[k]) if (sb[k].a[31:4] == la[31:4]) hit = 1'b1;
    chk("lookup_hit", lookup_hit, hit);
    chk("mem_req_valid", mem_req_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("mem_req_addr", mem_req_addr, sb[0].a);
      chk("mem_req_data", mem_req_data, sb[0].d);
      chk("mem_req_size", mem_req_size, sb[0].s);
    end
    n = sb.size();
    if (ev && n == DEPTH) movf = 1'b1;
    if (rdy && n != 0) void'(sb.pop_front());
    if (ev && n < DEPTH) sb.push_back('{a: a, d: d, s: s});
    @(negedge clk);
    chk("count", count, sb.size());
    chk("full", full, sb.size() == DEPTH);
    chk("empty", empty, sb.size() == 0);
    chk("ovf", ovf, movf);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) step(1'b0, '0, '0, '0, 1'b1, 32'hFFFF_FFF0);
    chk("drained", sb.size(), 0);
  endtask

  initial begin
    #1;
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_valid", mem_req_valid, 0);
    chk("rst_hit", lookup_hit, 0);
    chk("rst_ovf", ovf, 0);
    #6 rst = 1'b1;
    @(negedge clk);
    // single store: visible one cycle after enqueue, gone after the dequeue edge
    step(1'b1, 32'h1000, 64'hAABB, 2'b10, 1'b0, 32'h1008);
    chk("single_addr", mem_req_addr, 32'h1000);
    step(1'b0, '0, '0, '0, 1'b1, 32'h1000);
    // fill to full, attempt an overflow, drain in order
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 32'h100 * i, 64'hC0DE_0000 + i, 2'(i), 1'b0, 32'h0);
    step(1'b1, 32'hDEAD_0000, 64'hBAD, 2'b11, 1'b0, 32'hDEAD_0000);
    chk("ovf_set", ovf, 1);
    step(1'b1, 32'hDEAD_0010, 64'hBAD1, 2'b11, 1'b1, 32'hDEAD_0010);
    drain();
    // simultaneous enqueue and dequeue at count 3
    for (int i = 0; i < 3; i++) step(1'b1, 32'h3000 + 32'h10 * i, 64'h30 + i, 2'b01, 1'b0, 32'h0);
    step(1'b1, 32'h3030, 64'h33, 2'b01, 1'b1, 32'h3010);
    chk("simul_count", count, 3);
    chk("simul_head", mem_req_addr, 32'h3010);
    drain();
    // 20 enqueue/dequeue pairs wrapping the pointers
    step(1'b1, 32'h4000, 64'h4000, 2'b11, 1'b0, 32'h0);
    for (int i = 1; i <= 20; i++) step(1'b1, 32'h4000 + 32'h40 * i, 64'h4000 + i, 2'(i), 1'b1, 32'h4000 + 32'h40 * (i - 1));
    drain();
    // line-granular lookup and same-cycle enqueue exclusion
    step(1'b1, 32'h5000, 64'h5, 2'b00, 1'b0, 32'h5000);
    step(1'b1, 32'h2034, 64'h2034, 2'b10, 1'b0, 32'h203C);
    step(1'b0, '0, '0, '0, 1'b0, 32'h203C);
    chk("hit_same_line", lookup_hit, 1);
    step(1'b0, '0, '0, '0, 1'b0, 32'h2040);
    step(1'b0, '0, '0, '0, 1'b1, 32'h2030);
    step(1'b0, '0, '0, '0, 1'b1, 32'h2030);
    step(1'b0, '0, '0, '0, 1'b0, 32'h2030);
    chk("hit_after_deq", lookup_hit, 0);
    // randomised traffic with occasional overflow attempts
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, la;
      a  = 32'h6000 + 32'($urandom_range(0, 15)) * 32'h8;
      la = 32'h6000 + 32'($urandom_range(0, 15)) * 32'h8;
      step(1'($urandom_range(0, 99) < 60), a, {$urandom, $urandom}, 2'($urandom), 1'($urandom_range(0, 99) < 45), la);
    end
    drain();
    // asynchronous reset with five pending stores
    for (int i = 0; i < 5; i++) step(1'b1, 32'h7000 + 32'h10 * i, 64'h70 + i, 2'b10, 1'b0, 32'h0);
    enq_valid = 1'b0; mem_req_ready = 1'b0; lookup_addr = 32'h7000;
    #2 rst = 1'b0;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_valid", mem_req_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_hit", lookup_hit, 0);
    sb.delete();
    movf = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    step(1'b1, 32'h8000, 64'h8888, 2'b01, 1'b0, 32'h7000);
    step(1'b0, '0, '0, '0, 1'b1, 32'h8004);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_addr_queue.md
WB_ADDR_QUEUE -- requirements
Module: wb_addr_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the entry count; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter PTRW, default 3, equal to log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 enq_valid  input  1  writeback memory store request (writeback mem_ld).
REQ-006 enq_addr  input  32  store address.
REQ-007 enq_data  input  64  store data.
REQ-008 enq_size  input  2  store size: 00=1B, 01=2B, 10=4B, 11=8B.
REQ-009 full  output  1  queue full; drives writeback wbaq_full.
REQ-010 empty  output  1  queue holds no entries.
REQ-011 count  output  PTRW+1  number of occupied entries.
REQ-012 mem_req_valid  output  1  head entry presented to the data cache.
REQ-013 mem_req_addr / mem_req_data / mem_req_size  output  32/64/2  head entry fields.
REQ-014 mem_req_ready  input  1  data cache accepts the head entry this cycle.
REQ-015 lookup_addr  input  32  load address checked for pending stores.
REQ-016 lookup_hit  output  1  a pending store matches the same 16-byte line.
REQ-017 ovf  output  1  sticky overflow error flag.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH entries {addr, data, size}, with head pointer, tail pointer and count registers.
REQ-019 full SHALL equal (count==DEPTH), and empty SHALL equal (count==0); both are decoded from registered count only.
REQ-020 An enqueue SHALL occur when enq_valid=1 and full=0: the entry is written at tail, and tail increments modulo DEPTH.
REQ-021 A dequeue SHALL occur when mem_req_valid=1 and mem_req_ready=1: head increments modulo DEPTH.
REQ-022 mem_req_valid SHALL equal ~empty, and mem_req_* fields SHALL be driven from the entry at head; there is no combinational path from enq_* to mem_req_*.
REQ-023 Enqueue-to-visibility latency SHALL be one cycle: an entry written at edge N appears on mem_req_* after edge N if the queue was empty.
REQ-024 On simultaneous enqueue and dequeue, count SHALL be unchanged and both pointers SHALL advance.
REQ-025 When full=1, enq_valid SHALL be ignored, even if a dequeue occurs in the same cycle; the entry is not written.
REQ-026 enq_valid=1 while full=1 SHALL set ovf, which stays set until reset; writeback stalls on full, so this is an illegal case.
REQ-027 When empty=1, mem_req_ready SHALL have no effect.
REQ-028 Pointer wrap-around from DEPTH-1 to 0 SHALL preserve FIFO order.
REQ-029 mem_req_* SHALL hold stable while mem_req_valid=1 and mem_req_ready=0.
REQ-030 lookup_hit SHALL be the combinational OR, over occupied entries, of (entry.addr[31:4]==lookup_addr[31:4]).
REQ-031 lookup_hit SHALL exclude entries being enqueued in the current cycle, and SHALL include the head entry until its dequeue edge.
REQ-032 Entry occupancy for lookup SHALL be derived from head/count, not from stale storage contents.

Reset
REQ-033 Assertion of rst=0 SHALL immediately clear head, tail, count and ovf, independent of clk.
REQ-034 After reset: full=0, empty=1, count=0, mem_req_valid=0, lookup_hit=0, ovf=0.
REQ-035 Entry storage contents need not be cleared on reset and SHALL be unobservable while unoccupied.
REQ-036 Reset mid-operation SHALL discard all pending stores; the first enqueue after rst deassertion writes entry 0.

Verification
REQ-037 Enqueue addr=0x1000, data=0xAABB, size=10 into an empty queue -> next cycle mem_req_valid=1, mem_req_addr=0x1000, count=1; with ready=1 -> empty=1 after the following edge.
REQ-038 Enqueue 8 stores with ready=0 -> full=1, count=8; a 9th enq_valid -> not written, ovf=1; drain -> the 8 entries emerge in order.
REQ-039 With count=3, enq_valid=1 and ready=1 in the same cycle -> count stays 3, and the head advances to the second entry.
REQ-040 Run 20 enqueue/dequeue pairs through DEPTH=8 -> wrap occurs, and the output data sequence equals the input sequence.
REQ-041 Pending store addr=0x2034; lookup_addr=0x203C -> hit=1; lookup_addr=0x2040 -> hit=0; after that entry dequeues -> hit=0.
REQ-042 With count=5, assert rst=0 between edges -> empty=1 and mem_req_valid=0 immediately, and ovf=0.
